// File: rtl/systolic_mm_ctrl.sv
// systolic_mm_ctrl: sequencer for the M x N * N x P systolic array (clear, feed, drain, stream rows); optional perf counters behind SYSTOLIC_MM_PERF_EN
module systolic_mm_ctrl #(
  parameter int BW = 16,
  parameter int M = 3,
  parameter int N = 4,
  parameter int P = 5,
  parameter int PE_LAT = 1,
  localparam int SM = (M + N - 1 > N + P - 1) ? M + N - 1 : N + P - 1,
  localparam int TOT = M + N + P - 2 + PE_LAT,
  localparam int DR = TOT - SM,
  localparam int CW = (SM > 1) ? $clog2(SM) : 1,
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int DW = (DR > 1) ? $clog2(DR) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          acc_clr,
  output logic          feed_en,
  output logic [CW-1:0] feed_idx,
  output logic          pe_en,
  output logic [RW-1:0] rd_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
`ifdef SYSTOLIC_MM_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stall
`endif
);
  if (BW < 1 || PE_LAT < 1) begin : g_bad_param
    $error("systolic_mm_ctrl: BW and PE_LAT must be at least 1");
  end
  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, OUT} state_t;
  state_t state;
  logic [DW-1:0] drain;
  // sequencer: phase transitions, beat/drain/row counters and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      feed_idx <= '0;
      drain <= '0;
      rd_row <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        feed_idx <= '0;
        drain <= '0;
        rd_row <= '0;
      end else begin
        case (state)
          IDLE: if (start) state <= CLR;
          CLR: begin
            state <= FEED;
            feed_idx <= '0;
            rd_row <= '0;
          end
          FEED: begin
            if (feed_idx == CW'(SM - 1)) begin
              state <= DRAIN;
              feed_idx <= '0;
              drain <= DW'(DR - 1);
            end else begin
              feed_idx <= feed_idx + CW'(1);
            end
          end
          DRAIN: begin
            if (drain == '0) state <= OUT;
            else drain <= drain - DW'(1);
          end
          OUT: begin
            if (out_ready) begin
              if (rd_row == RW'(M - 1)) begin
                state <= IDLE;
                rd_row <= '0;
                done <= 1'b1;
              end else begin
                rd_row <= rd_row + RW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign busy = state != IDLE;
  assign acc_clr = state == CLR;
  assign feed_en = state == FEED;
  assign pe_en = state == FEED || state == DRAIN;
  assign out_valid = state == OUT;
`ifdef SYSTOLIC_MM_PERF_EN
  // job cycle and output-stall counters; frozen on abort and while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall <= '0;
    end else if (!abort) begin
      if (state == CLR) begin
        perf_cycles <= 32'd1;
        perf_stall <= '0;
      end else begin
        if (state != IDLE) perf_cycles <= (&perf_cycles) ? perf_cycles : perf_cycles + 32'd1;
        if (state == OUT && !out_ready) perf_stall <= (&perf_stall) ? perf_stall : perf_stall + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// tb_systolic_mm_ctrl: directed and random checks of systolic_mm_ctrl against a job-timeline model
module tb_systolic_mm_ctrl;
  localparam int M = 3, N = 4, P = 5, PE_LAT = 1;
  localparam int SM = (M + N - 1 > N + P - 1) ? M + N - 1 : N + P - 1;
  localparam int DR = M + N + P - 2 + PE_LAT - SM;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic busy, acc_clr, feed_en, pe_en, out_valid, done;
  logic [2:0] feed_idx;
  logic [1:0] rd_row;
  logic start_s = 1'b0;
  logic busy_s, acc_clr_s, feed_en_s, pe_en_s, out_valid_s, done_s;
  logic [0:0] feed_idx_s, rd_row_s;
`ifdef SYSTOLIC_MM_PERF_EN
  logic [31:0] perf_cycles, perf_stall, perf_cycles_s, perf_stall_s;
`endif
  int n_cmp = 0, n_err = 0;
  bit m_act = 0, m_done = 0;
  int m_t = 0, m_rows = 0, m_pc = 0, m_ps = 0;

  always #5 clk = ~clk;

  systolic_mm_ctrl #(.BW(16), .M(M), .N(N), .P(P), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .acc_clr(acc_clr),
    .feed_en(feed_en), .feed_idx(feed_idx), .pe_en(pe_en), .rd_row(rd_row), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
`ifdef SYSTOLIC_MM_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  systolic_mm_ctrl #(.BW(16), .M(1), .N(2), .P(1), .PE_LAT(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .busy(busy_s), .acc_clr(acc_clr_s),
    .feed_en(feed_en_s), .feed_idx(feed_idx_s), .pe_en(pe_en_s), .rd_row(rd_row_s), .out_valid(out_valid_s),
    .out_ready(1'b1), .done(done_s)
`ifdef SYSTOLIC_MM_PERF_EN
    , .perf_cycles(perf_cycles_s), .perf_stall(perf_stall_s)
`endif
  );

  function automatic bit e_fe(); return m_act && m_t >= 2 && m_t <= SM + 1; endfunction
  function automatic bit e_pe(); return m_act && m_t >= 2 && m_t <= SM + DR + 1; endfunction
  function automatic bit e_ov(); return m_act && m_t >= SM + DR + 2; endfunction
  function automatic int e_fi(); return e_fe() ? m_t - 2 : 0; endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_act);
    chk("acc_clr", acc_clr, m_act && m_t == 1);
    chk("feed_en", feed_en, e_fe());
    chk("feed_idx", feed_idx, e_fi());
    chk("pe_en", pe_en, e_pe());
    chk("out_valid", out_valid, e_ov());
    chk("rd_row", rd_row, e_ov() ? m_rows : 0);
    chk("done", done, m_done);
`ifdef SYSTOLIC_MM_PERF_EN
    chk("perf_cycles", perf_cycles, m_pc);
    chk("perf_stall", perf_stall, m_ps);
`endif
  endtask

  task automatic model_update(input bit s, input bit a, input bit r);
    bit nd = 0;
    if (m_act) begin
      if (a) m_act = 0;
      else begin
        if (m_t == 1) begin m_pc = 1; m_ps = 0; end
        else m_pc++;
        if (e_ov() && !r) m_ps++;
        if (e_ov() && r) begin
          m_rows++;
          if (m_rows == M) begin m_act = 0; nd = 1; end
        end
        m_t++;
      end
    end else if (s) begin
      m_act = 1; m_t = 1; m_rows = 0;
    end
    m_done = nd;
  endtask

  task automatic step(input bit s, input bit a, input bit r);
    start = s; abort = a; out_ready = r;
    check_all();
    @(posedge clk);
    model_update(s, a, r);
    @(negedge clk);
  endtask

  initial begin
    int done_at, clr2, stalls, bound, cyc;
    bit r;
    #2;
    check_all();
    chk("reset_small_busy", busy_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(0, 0, 1);

    step(1, 0, 1);
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1 && done_at < 0) done_at = k;
      step(0, 0, 1);
    end
    chk("done_latency", done_at, 16);

    step(1, 0, 1);
    done_at = -1; stalls = 0;
    for (int k = 1; k <= 25; k++) begin
      r = !(e_ov() && m_rows == 1 && stalls < 4);
      if (!r) stalls++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      step(0, 0, r);
    end
    chk("stall_done_latency", done_at, 20);
`ifdef SYSTOLIC_MM_PERF_EN
    chk("perf_cycles_19", perf_cycles, 19);
    chk("perf_stall_4", perf_stall, 4);
`endif

    clr2 = -1;
    for (int k = 0; k < 30; k++) begin
      if (acc_clr === 1'b1 && k > 1 && clr2 < 0) clr2 = k;
      step(1, 0, 1);
    end
    chk("back_to_back_clr", clr2, 17);
    repeat (20) step(0, 0, 1);

    step(1, 0, 1);
    bound = 0;
    while (!(e_fe() && e_fi() == 5) && bound < 20) begin step(0, 0, 1); bound++; end
    chk("abort_reached_idx5", feed_idx, 5);
    step(0, 1, 1);
    chk("abort_idle", busy, 0);
    repeat (3) step(0, 0, 1);
    step(1, 0, 1);
    repeat (18) step(0, 0, 1);

    for (int k = 0; k < 800; k++)
      step($urandom_range(99) < 30, $urandom_range(99) < 3, $urandom_range(99) < 70);
    repeat (30) step(0, 0, 1);

    step(1, 0, 1);
    bound = 0;
    while (!(e_ov() && m_rows == 1) && bound < 30) begin step(0, 0, 1); bound++; end
    chk("reached_row1", rd_row, 1);
    #2 rst_n = 1'b0;
    #1;
    m_act = 0; m_done = 0; m_pc = 0; m_ps = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(0, 0, 1);

    start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    cyc = 1; done_at = -1; stalls = 0; clr2 = 0;
    while (done_at < 0 && cyc < 20) begin
      if (out_valid_s === 1'b1) stalls++;
      if (acc_clr_s === 1'b1) clr2++;
      if (rd_row_s !== 1'b0) chk("small_rd_row", rd_row_s, 0);
      if (done_s === 1'b1) done_at = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("small_done_latency", done_at, 7);
    chk("small_out_beats", stalls, 1);
    chk("small_clr_beats", clr2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
